// File: rtl/dma_host_responder.sv
`timescale 1ns/1ps
// dma_host_responder: host-side responder for the cache-line DMA read/write protocol.
// An on-chip line memory feeds a show-ahead read FIFO and absorbs a draining write FIFO.
module dma_host_responder #(
   parameter int unsigned  DATA_WIDTH = 512,
   parameter int unsigned  ADDR_WIDTH = 64,
   parameter int unsigned  SIZE_WIDTH = 43,
   parameter int unsigned  MEM_LINES  = 256,
   parameter int unsigned  FIFO_DEPTH = 8,
   localparam int unsigned LW         = $clog2(MEM_LINES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_go,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [SIZE_WIDTH-1:0] rd_size,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  rd_done,
   input  logic                  wr_go,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [SIZE_WIDTH-1:0] wr_size,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  host_wr_completed,
   output logic                  wr_done,
   input  logic                  bd_we,
   input  logic [LW-1:0]         bd_addr,
   input  logic [DATA_WIDTH-1:0] bd_wdata,
   output logic [DATA_WIDTH-1:0] bd_rdata
);

   localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_DONE} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DONE} wr_state_t;

   logic [DATA_WIDTH-1:0] r_mem [MEM_LINES];

   rd_state_t             r_rd_state;
   logic [LW-1:0]         r_rd_base;
   logic [SIZE_WIDTH-1:0] r_rd_size;
   logic [SIZE_WIDTH-1:0] r_rd_issued;
   logic [SIZE_WIDTH-1:0] r_rd_popped;
   logic [DATA_WIDTH-1:0] r_rd_fifo [FIFO_DEPTH];
   logic [PW-1:0]         r_rd_wptr;
   logic [PW-1:0]         r_rd_rptr;
   logic [CW-1:0]         r_rd_cnt;
   logic                  r_rd_done;

   wr_state_t             r_wr_state;
   logic [LW-1:0]         r_wr_base;
   logic [SIZE_WIDTH-1:0] r_wr_size;
   logic [SIZE_WIDTH-1:0] r_wr_acc;
   logic [SIZE_WIDTH-1:0] r_wr_committed;
   logic [DATA_WIDTH-1:0] r_wr_fifo [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_wptr;
   logic [PW-1:0]         r_wr_rptr;
   logic [CW-1:0]         r_wr_cnt;
   logic                  r_wr_hwc;
   logic                  r_wr_done;

   logic                  w_rd_issue;
   logic                  w_rd_pop;
   logic [LW-1:0]         w_rd_idx;
   logic                  w_wr_full;
   logic                  w_wr_push;
   logic                  w_wr_pop;
   logic [LW-1:0]         w_wr_idx;
   logic                  w_bd_we;
   logic                  w_unused;

   // Sub-line byte offset and address bits above the memory are not decoded.
   assign w_unused = ^{rd_addr[5:0], rd_addr[ADDR_WIDTH-1:6+LW],
                       wr_addr[5:0], wr_addr[ADDR_WIDTH-1:6+LW]};

   // Issue only while the FIFO has room; read data lands in the FIFO at the issue edge.
   assign w_rd_issue = (r_rd_state == R_ACTIVE) && (r_rd_issued < r_rd_size) &&
                       (r_rd_cnt < DEPTH_C);
   assign w_rd_pop   = rd_en && (r_rd_cnt != '0);
   assign w_rd_idx   = r_rd_base + r_rd_issued[LW-1:0];

   assign rd_data    = r_rd_fifo[r_rd_rptr];
   assign empty      = (r_rd_cnt == '0);
   assign rd_done    = r_rd_done;

   assign w_wr_full  = !((r_wr_state == W_ACTIVE) && (r_wr_cnt < DEPTH_C) &&
                         (r_wr_acc < r_wr_size));
   assign w_wr_push  = wr_en && !w_wr_full;
   assign w_wr_pop   = (r_wr_state == W_ACTIVE) && (r_wr_cnt != '0);
   assign w_wr_idx   = r_wr_base + r_wr_committed[LW-1:0];
   assign w_bd_we    = bd_we && (r_wr_state != W_ACTIVE);

   assign full              = w_wr_full;
   assign host_wr_completed = r_wr_hwc;
   assign wr_done           = r_wr_done;

   // Read channel FSM and FIFO bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_state  <= R_IDLE;
         r_rd_base   <= '0;
         r_rd_size   <= '0;
         r_rd_issued <= '0;
         r_rd_popped <= '0;
         r_rd_wptr   <= '0;
         r_rd_rptr   <= '0;
         r_rd_cnt    <= '0;
         r_rd_done   <= 1'b0;
      end else begin
         if (w_rd_issue) begin
            r_rd_issued <= r_rd_issued + SIZE_WIDTH'(1);
            r_rd_wptr   <= r_rd_wptr + PW'(1);
         end
         if (w_rd_pop) begin
            r_rd_popped <= r_rd_popped + SIZE_WIDTH'(1);
            r_rd_rptr   <= r_rd_rptr + PW'(1);
         end
         r_rd_cnt <= r_rd_cnt + CW'(w_rd_issue) - CW'(w_rd_pop);
         case (r_rd_state)
            R_ACTIVE: begin
               if (w_rd_pop && (r_rd_popped == r_rd_size - SIZE_WIDTH'(1))) begin
                  r_rd_state <= R_DONE;
                  r_rd_done  <= 1'b1;
               end
            end
            default: begin
               if (rd_go) begin
                  r_rd_base   <= rd_addr[6 +: LW];
                  r_rd_size   <= rd_size;
                  r_rd_issued <= '0;
                  r_rd_popped <= '0;
                  r_rd_wptr   <= '0;
                  r_rd_rptr   <= '0;
                  r_rd_cnt    <= '0;
                  if (rd_size == '0) begin
                     r_rd_state <= R_DONE;
                     r_rd_done  <= 1'b1;
                  end else begin
                     r_rd_state <= R_ACTIVE;
                     r_rd_done  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd_issue) begin
         r_rd_fifo[r_rd_wptr] <= r_mem[w_rd_idx];
      end
   end

   // Write channel FSM and FIFO bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state     <= W_IDLE;
         r_wr_base      <= '0;
         r_wr_size      <= '0;
         r_wr_acc       <= '0;
         r_wr_committed <= '0;
         r_wr_wptr      <= '0;
         r_wr_rptr      <= '0;
         r_wr_cnt       <= '0;
         r_wr_hwc       <= 1'b0;
         r_wr_done      <= 1'b0;
      end else begin
         if (w_wr_push) begin
            r_wr_acc  <= r_wr_acc + SIZE_WIDTH'(1);
            r_wr_wptr <= r_wr_wptr + PW'(1);
         end
         if (w_wr_pop) begin
            r_wr_committed <= r_wr_committed + SIZE_WIDTH'(1);
            r_wr_rptr      <= r_wr_rptr + PW'(1);
         end
         r_wr_cnt <= r_wr_cnt + CW'(w_wr_push) - CW'(w_wr_pop);
         case (r_wr_state)
            W_ACTIVE: begin
               if (w_wr_push && (r_wr_acc == r_wr_size - SIZE_WIDTH'(1))) begin
                  r_wr_hwc <= 1'b1;
               end
               if (w_wr_pop && (r_wr_committed == r_wr_size - SIZE_WIDTH'(1))) begin
                  r_wr_state <= W_DONE;
                  r_wr_done  <= 1'b1;
               end
            end
            default: begin
               if (wr_go) begin
                  r_wr_base      <= wr_addr[6 +: LW];
                  r_wr_size      <= wr_size;
                  r_wr_acc       <= '0;
                  r_wr_committed <= '0;
                  r_wr_wptr      <= '0;
                  r_wr_rptr      <= '0;
                  r_wr_cnt       <= '0;
                  if (wr_size == '0) begin
                     r_wr_state <= W_DONE;
                     r_wr_hwc   <= 1'b1;
                     r_wr_done  <= 1'b1;
                  end else begin
                     r_wr_state <= W_ACTIVE;
                     r_wr_hwc   <= 1'b0;
                     r_wr_done  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_push) begin
         r_wr_fifo[r_wr_wptr] <= wr_data;
      end
   end

   // Single memory write port: drain has priority; backdoor only outside W_ACTIVE.
   always_ff @(posedge clk) begin
      if (w_wr_pop) begin
         r_mem[w_wr_idx] <= r_wr_fifo[r_wr_rptr];
      end else if (w_bd_we) begin
         r_mem[bd_addr] <= bd_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bd_rdata <= '0;
      end else begin
         bd_rdata <= r_mem[bd_addr];
      end
   end

endmodule

// File: tb/tb_dma_host_responder.sv
`timescale 1ns/1ps
// Directed self-checking bench for dma_host_responder.
module tb_dma_host_responder;

   localparam int unsigned DW = 512;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_go, rd_en, empty, rd_done;
   logic [63:0]   rd_addr, wr_addr;
   logic [42:0]   rd_size, wr_size;
   logic [DW-1:0] rd_data, wr_data, bd_wdata, bd_rdata;
   logic          wr_go, wr_en, full, host_wr_completed, wr_done;
   logic          bd_we;
   logic [7:0]    bd_addr;

   logic [DW-1:0] model [256];
   int            checks = 0;
   int            errors = 0;

   dma_host_responder dut (
      .clk(clk), .rst_n(rst_n),
      .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
      .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
      .wr_data(wr_data), .full(full), .host_wr_completed(host_wr_completed),
      .wr_done(wr_done),
      .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic bd_wr(input int line, input logic [DW-1:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 8'(line); bd_wdata = d;
      model[line] = d;
   endtask

   task automatic bd_chk(input int line);
      @(negedge clk);
      bd_addr = 8'(line);
      @(negedge clk);
      chk($sformatf("bd_line%0d", line), bd_rdata, model[line]);
   endtask

   task automatic rd_xfer(input logic [63:0] addr, input int size, input int hold, input bit lat);
      int base, k, cyc;
      base = int'(addr[13:6]);
      @(negedge clk);
      rd_go = 1'b1; rd_addr = addr; rd_size = 43'(size);
      @(negedge clk);
      rd_go = 1'b0;
      if (lat) begin
         chk1("rd_empty_cyc1", empty, 1'b1);
         @(negedge clk);
         chk1("rd_empty_cyc2", empty, 1'b0);
      end
      repeat (hold) @(negedge clk);
      if (hold > 0) chk1("rd_buffered_after_hold", empty, 1'b0);
      k = 0; cyc = 0;
      while (k < size && cyc < 200) begin
         if (!empty) begin
            if (k == size - 1) chk1("rd_done_before_last", rd_done, 1'b0);
            chk($sformatf("rd_line%0d", k), rd_data, model[(base + k) % 256]);
            rd_en = 1'b1;
            k++;
         end else begin
            rd_en = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      rd_en = 1'b0;
      chk("rd_popped", DW'(k), DW'(size));
      chk1("rd_done", rd_done, 1'b1);
      chk1("rd_empty_end", empty, 1'b1);
      @(negedge clk);
      chk1("rd_done_held", rd_done, 1'b1);
   endtask

   task automatic wr_xfer(input logic [63:0] addr, input int size, input logic [DW-1:0] d0);
      int base, k, cyc;
      base = int'(addr[13:6]);
      @(negedge clk);
      wr_go = 1'b1; wr_addr = addr; wr_size = 43'(size);
      @(negedge clk);
      wr_go = 1'b0;
      k = 0; cyc = 0;
      while (k < size && cyc < 100) begin
         if (!full) begin
            if (k == size - 1) chk1("hwc_before_last", host_wr_completed, 1'b0);
            wr_en = 1'b1;
            wr_data = d0 + DW'(k);
            model[(base + k) % 256] = wr_data;
            k++;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk("wr_pushed", DW'(k), DW'(size));
      chk1("hwc", host_wr_completed, 1'b1);
      chk1("full_after_last", full, 1'b1);
      chk1("wr_done_lags", wr_done, 1'b0);
      wr_en = 1'b1;
      wr_data = DW'('hEE);
      cyc = 0;
      do begin
         @(negedge clk);
         wr_en = 1'b0;
         cyc++;
      end while (!wr_done && cyc < 100);
      chk1("wr_done", wr_done, 1'b1);
   endtask

   initial begin
      int rk, wk, cyc;
      rst_n = 1'b0;
      rd_go = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_size = '0;
      wr_go = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
      bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
      repeat (3) @(negedge clk);
      chk1("rst_empty", empty, 1'b1);
      chk1("rst_full", full, 1'b1);
      chk1("rst_rd_done", rd_done, 1'b0);
      chk1("rst_wr_done", wr_done, 1'b0);
      chk1("rst_hwc", host_wr_completed, 1'b0);
      chk("rst_bd_rdata", bd_rdata, '0);
      rst_n = 1'b1;

      // Preload: lines 0..3 = A0..A3, lines 4..31 = C00+i.
      for (int i = 0; i < 32; i++) bd_wr(i, (i < 4) ? DW'('hA0 + i) : DW'('hC00 + i));
      @(negedge clk);
      bd_we = 1'b0;
      chk1("idle_full", full, 1'b1);

      rd_xfer(64'h0, 4, 0, 1'b1);

      wr_xfer(64'h40, 3, DW'('hB1));
      bd_chk(1); bd_chk(2); bd_chk(3); bd_chk(4);

      rd_xfer(64'h0, 12, 20, 1'b0);

      // Wrap from line 255 to line 0.
      wr_xfer(64'h3FC0, 2, DW'('hD0));
      bd_chk(255); bd_chk(0);

      // Zero-size transfers on both channels in the same cycle.
      @(negedge clk);
      rd_go = 1'b1; rd_addr = 64'h80; rd_size = '0;
      wr_go = 1'b1; wr_addr = 64'h80; wr_size = '0;
      @(negedge clk);
      rd_go = 1'b0; wr_go = 1'b0;
      chk1("z_rd_done", rd_done, 1'b1);
      chk1("z_wr_done", wr_done, 1'b1);
      chk1("z_hwc", host_wr_completed, 1'b1);
      chk1("z_empty", empty, 1'b1);
      chk1("z_full", full, 1'b1);
      bd_chk(2);

      // Concurrent read of lines 10..13 and write of lines 20..23.
      @(negedge clk);
      rd_go = 1'b1; rd_addr = 64'h280; rd_size = 43'd4;
      wr_go = 1'b1; wr_addr = 64'h500; wr_size = 43'd4;
      @(negedge clk);
      rd_go = 1'b0; wr_go = 1'b0;
      bd_we = 1'b1; bd_addr = 8'd30; bd_wdata = DW'('hFF);
      rk = 0; wk = 0; cyc = 0;
      while (!(rd_done && wr_done) && cyc < 60) begin
         if (!empty && (cyc % 2 == 0)) begin
            chk($sformatf("cc_rd_line%0d", rk), rd_data, model[10 + rk]);
            rd_en = 1'b1;
            rk++;
         end else begin
            rd_en = 1'b0;
         end
         if (!full && (cyc % 3 != 1)) begin
            wr_en = 1'b1;
            wr_data = DW'('hE0 + wk);
            model[20 + wk] = wr_data;
            wk++;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         bd_we = 1'b0;
         cyc++;
      end
      rd_en = 1'b0; wr_en = 1'b0;
      chk("cc_rd_count", DW'(rk), DW'(4));
      chk("cc_wr_count", DW'(wk), DW'(4));
      chk1("cc_rd_done", rd_done, 1'b1);
      chk1("cc_wr_done", wr_done, 1'b1);
      chk1("cc_hwc", host_wr_completed, 1'b1);
      bd_chk(20); bd_chk(21); bd_chk(22); bd_chk(23); bd_chk(30);

      // Asynchronous reset in the middle of a read after two pops.
      @(negedge clk);
      rd_go = 1'b1; rd_addr = 64'h0; rd_size = 43'd4;
      @(negedge clk);
      rd_go = 1'b0;
      @(negedge clk);
      chk("mr_line0", rd_data, model[0]);
      rd_en = 1'b1;
      @(negedge clk);
      chk("mr_line1", rd_data, model[1]);
      @(negedge clk);
      rd_en = 1'b0;
      chk1("mr_pre_empty", empty, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk1("mr_empty", empty, 1'b1);
      chk1("mr_full", full, 1'b1);
      chk1("mr_rd_done", rd_done, 1'b0);
      chk1("mr_wr_done", wr_done, 1'b0);
      chk1("mr_hwc", host_wr_completed, 1'b0);
      chk("mr_bd_rdata", bd_rdata, '0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_xfer(64'h140, 2, 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_host_responder.md
Name: dma_host_responder

Overview:
- Responder (host/memory end) of the cache-line DMA read/write protocol driven by the AFU's DMA initiator logic (MMU host port).
- Backs both channels with an on-chip line memory: services rd_go by streaming lines into a show-ahead read FIFO, and accepts written lines into a write FIFO that drains to memory.
- Used as a synthesizable host stand-in for standalone bring-up and simulation of the CPU/MMU without the CCI-P HAL; a backdoor port preloads and checks memory.

Parameters:
DATA_WIDTH, 512, cache-line width in bits
ADDR_WIDTH, 64, virtual byte address width
SIZE_WIDTH, 43, transfer size width in lines (CL address width + 1)
MEM_LINES, 256, memory depth in lines (power of 2); LW = log2(MEM_LINES)
FIFO_DEPTH, 8, depth of each channel FIFO (power of 2, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_go  in  1  start read transfer (1-cycle pulse)
rd_addr  in  ADDR_WIDTH  starting byte address of read
rd_size  in  SIZE_WIDTH  lines to read
rd_en  in  1  pop head of read FIFO
rd_data  out  DATA_WIDTH  read FIFO head (show-ahead)
empty  out  1  read FIFO empty
rd_done  out  1  all rd_size lines popped; held until next rd_go
wr_go  in  1  start write transfer (1-cycle pulse)
wr_addr  in  ADDR_WIDTH  starting byte address of write
wr_size  in  SIZE_WIDTH  lines to write
wr_en  in  1  push wr_data
wr_data  in  DATA_WIDTH  write line
full  out  1  write channel cannot accept
host_wr_completed  out  1  wr_size lines accepted; held until next wr_go
wr_done  out  1  all lines committed to memory; held until next wr_go
bd_we  in  1  backdoor write strobe
bd_addr  in  LW  backdoor line index
bd_wdata  in  DATA_WIDTH  backdoor write data
bd_rdata  out  DATA_WIDTH  backdoor read data, 1-cycle registered

Behaviour:
- Line index = addr[6 +: LW]; low 6 bits ignored; base+offset wraps modulo MEM_LINES.
- Memory: one synchronous read port (read engine), one write port (drain, else backdoor); read-during-write same line returns old data.
- Reset: empty=1, full=1, rd_done=0, wr_done=0, host_wr_completed=0, bd_rdata=0, FIFOs flushed, both FSMs idle. Memory contents not reset.
- Read FSM R_IDLE/R_ACTIVE/R_DONE:
  - rd_go in R_IDLE or R_DONE: latch base/size, clear counters, rd_done=0, flush read FIFO; size 0 -> R_DONE (rd_done=1 next cycle), else R_ACTIVE. rd_go in R_ACTIVE ignored.
  - Issue one memory read per cycle while issued<size and fifo_count+inflight<FIFO_DEPTH; data enters FIFO the cycle after issue; first line visible (empty=0) 2 cycles after rd_go.
  - rd_en with empty=1 ignored; simultaneous push and pop keeps count.
  - Pop of line size-1 -> R_DONE; rd_done=1 the next cycle.
- Write FSM W_IDLE/W_ACTIVE/W_DONE:
  - wr_go in W_IDLE or W_DONE: latch base/size, clear counters, wr_done=0, host_wr_completed=0; size 0 -> W_DONE with host_wr_completed=1 and wr_done=1 next cycle. wr_go in W_ACTIVE ignored.
  - full=1 unless W_ACTIVE and fifo_count<FIFO_DEPTH and accepted<size.
  - wr_en with full=1 dropped; accepted push increments accepted; host_wr_completed=1 the cycle after accepted reaches size.
  - Drain pops one line per cycle when FIFO non-empty, writes base+committed; simultaneous push/pop allowed.
  - After commit of line size-1 -> W_DONE; wr_done=1 the next cycle.
- Backdoor: bd_we honored only when write FSM not W_ACTIVE, else dropped; bd_rdata = mem[bd_addr] registered every cycle.
- Channels independent; rd_go and wr_go in the same cycle both accepted.
- rst_n low mid-transfer: immediate abort to reset values; partially committed lines stay in memory.

Test Plan:
- Backdoor load lines 0..3 = 0xA0..0xA3; rd_go addr 0x0 size 4, rd_en whenever !empty -> rd_data 0xA0,0xA1,0xA2,0xA3 in order, empty=0 at cycle 2, rd_done=1 one cycle after 4th pop, stays 1.
- wr_go addr 0x40 size 3, push 0xB1,0xB2,0xB3 back-to-back -> host_wr_completed=1 after 3rd push, extra wr_en dropped, wr_done=1; backdoor reads lines 1..3 = 0xB1..0xB3, line 4 unchanged.
- rd_go size 12, no rd_en for 20 cycles -> exactly 8 lines buffered, no further issues; then pop all 12 correct, rd_done=1.
- Wrap: wr_go addr 0x3FC0 (line 255) size 2 -> lines 255 and 0 written; rd_go size 0 and wr_go size 0 -> rd_done, wr_done, host_wr_completed =1 next cycle, no memory access.
- Simultaneous rd_go (line 10, size 4) and wr_go (line 20, size 4) with interleaved traffic -> both complete correctly; bd_we during W_ACTIVE is dropped.
- Assert rst_n=0 mid-read after 2 pops -> empty=1, full=1, all done flags 0 asynchronously; new rd_go after release restarts cleanly.
